fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed-delay instruction request counter in front of the pipeline's F/D register. It owns the fetch PC, drives a req/ack instruction-memory handshake, retries aborted requests, and buffers fetched instructions with their PC+4 in a DEPTH-entry prefetch FIFO. Decode consumes entries with a ready/valid handshake, and branch/jump redirects from stage D flush the FIFO and discard stale in-flight data.

---
 rtl/fetch_queue.sv | 182 ++++++++++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the fetch PC, runs a
// req/ack handshake to instruction memory with abort retry, and buffers
// {instr, pc+4} pairs in a DEPTH-entry prefetch FIFO. Redirects from D
// flush the FIFO and drop any data still in flight for the old path.
module fetch_queue #(
  parameter int             W        = 32,
  parameter int             DEPTH    = 4,
  parameter logic [W-1:0]   RESET_PC = '0,
  parameter int             MAX_WAIT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [W-1:0]               imem_adr,
  input  logic                       imem_ack,
  input  logic                       imem_abort,
  input  logic [W-1:0]               imem_rdata,
  output logic                       instr_valid,
  output logic [W-1:0]               instr,
  output logic [W-1:0]               instr_pc4,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [W-1:0]               redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       fetch_timeout
);

  localparam int           AW      = $clog2(DEPTH);
  localparam int           OW      = $clog2(DEPTH + 1);
  localparam int           CW      = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] PC_STEP = W'(4);

  typedef enum logic [1:0] {IDLE, REQ, BACKOFF, DISCARD} state_t;

  state_t        state;
  logic [W-1:0]  pc;
  logic [CW-1:0] wait_cnt;
  logic [W-1:0]  mem_instr [DEPTH];
  logic [W-1:0]  mem_pc4   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic          push;
  logic          pop;
  logic [OW-1:0] occ_next;
  logic          room;
  logic [W-1:0]  pc_plus4;

  assign instr_valid = (occupancy != '0);
  assign instr       = mem_instr[rd_ptr];
  assign instr_pc4   = mem_pc4[rd_ptr];

  // Push/pop decisions and the occupancy that results from them.
  always_comb begin
    pop      = instr_valid && instr_ready && !redirect;
    push     = (state == REQ) && imem_ack && !redirect;
    occ_next = occupancy + OW'(push) - OW'(pop);
    room     = (occ_next < OW'(DEPTH));
    pc_plus4 = pc + PC_STEP;
  end

  // Prefetch FIFO storage and pointers; a redirect empties it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc4[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_rdata;
        mem_pc4[wr_ptr]   <= pc_plus4;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occupancy <= occ_next;
    end
  end

  // Fetch FSM: issue, retry after abort, discard stale data after redirect,
  // plus the wait counter behind the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      imem_adr      <= RESET_PC;
      wait_cnt      <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      // Count stalled request cycles; any new issue below clears the count.
      if (imem_req && !imem_ack && !imem_abort) begin
        if (wait_cnt != CW'(MAX_WAIT)) begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        if (wait_cnt == CW'(MAX_WAIT - 1)) begin
          fetch_timeout <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            pc       <= redirect_pc;
            state    <= REQ;
            imem_req <= 1'b1;
            imem_adr <= redirect_pc;
            wait_cnt <= '0;
          end else if (room) begin
            state    <= REQ;
            imem_req <= 1'b1;
            imem_adr <= pc;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_ack || imem_abort) begin
              // Current request is finished; its data (if any) is dropped.
              state    <= REQ;
              imem_req <= 1'b1;
              imem_adr <= redirect_pc;
              wait_cnt <= '0;
            end else begin
              // Keep the old request on the bus until memory completes it.
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (room) begin
              imem_adr <= pc_plus4;
              wait_cnt <= '0;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (imem_abort) begin
            state    <= BACKOFF;
            imem_req <= 1'b0;
          end
        end
        BACKOFF: begin
          state    <= REQ;
          imem_req <= 1'b1;
          wait_cnt <= '0;
          if (redirect) begin
            pc       <= redirect_pc;
            imem_adr <= redirect_pc;
          end else begin
            imem_adr <= pc;
          end
        end
        DISCARD: begin
          if (redirect) begin
            pc <= redirect_pc;
          end
          if (imem_ack || imem_abort) begin
            state    <= REQ;
            imem_req <= 1'b1;
            imem_adr <= redirect ? redirect_pc : pc;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven fill/resume vectors, a scoreboard that
// tracks every accepted fetch and checks it when decode pops it, and
// hand-written sequences for abort, redirect and timeout corner cases.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic        imem_ack;
  logic        imem_abort;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc4;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;
  logic        fetch_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } ent_t;
  ent_t sb[$];
  logic stale = 1'b0;

  typedef struct {
    logic        rdy;
    logic        ack;
    logic        req_e;
    logic [31:0] adr_e;
    logic [2:0]  occ_e;
  } vec_t;
  vec_t vt[9];

  fetch_queue #(.W(32), .DEPTH(4), .RESET_PC(32'h0), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_adr(imem_adr), .imem_ack(imem_ack),
    .imem_abort(imem_abort), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc4(instr_pc4),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .fetch_timeout(fetch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0011;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: drive the memory response, update the scoreboard, advance.
  task automatic tick(input logic a_en, input logic ab_en);
    ent_t e;
    imem_ack   = imem_req && a_en;
    imem_abort = imem_req && ab_en;
    imem_rdata = imem_req ? mem_word(imem_adr) : 32'h0;
    if (!reset) begin
      sb.delete();
      stale = 1'b0;
    end else begin
      if (instr_valid && instr_ready && !redirect) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_empty: got pop of 0x%0h expected no valid entry", instr);
        end else begin
          e = sb.pop_front();
          check("pop_instr", instr, e.ins);
          check("pop_pc4", instr_pc4, e.pc4);
        end
      end
      if (imem_req && imem_ack && !redirect && !stale)
        sb.push_back('{mem_word(imem_adr), imem_adr + 32'd4});
      if (redirect) sb.delete();
      if (imem_req && (imem_ack || imem_abort)) stale = 1'b0;
      else if (redirect && imem_req) stale = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    //            rdy   ack   req   adr           occ
    vt[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 3'd0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 3'd1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 3'd2};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 3'd3};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 3'd4};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 3'd4};
    vt[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 3'd3};
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 3'd3};
    vt[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 3'd4};

    imem_ack = 1'b0; imem_abort = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    do_reset();

    // Reset values
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_adr", imem_adr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", instr_pc4, 32'h0);
    check("rst_occ", {29'd0, occupancy}, 32'd0);
    check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);

    // Fill with decode stalled, then resume
    for (int i = 0; i < 9; i++) begin
      instr_ready = vt[i].rdy;
      tick(vt[i].ack, 1'b0);
      check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req_e});
      check($sformatf("vec%0d_adr", i), imem_adr, vt[i].adr_e);
      check($sformatf("vec%0d_occ", i), {29'd0, occupancy}, {29'd0, vt[i].occ_e});
    end

    // Zero-wait streaming: one instruction per cycle
    do_reset();
    instr_ready = 1'b1;
    tick(1'b1, 1'b0);
    check("stream_first_adr", imem_adr, 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0);
      check($sformatf("stream%0d_adr", k), imem_adr, 32'd4 * (k + 1));
      check($sformatf("stream%0d_occ", k), {29'd0, occupancy}, 32'd1);
    end

    // Abort on 0x8, backoff, reissue, then ack+abort together
    do_reset();
    instr_ready = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("abort_pre_adr", imem_adr, 32'h8);
    tick(1'b0, 1'b1);
    check("abort_backoff_req", {31'd0, imem_req}, 32'd0);
    tick(1'b0, 1'b0);
    check("abort_reissue_req", {31'd0, imem_req}, 32'd1);
    check("abort_reissue_adr", imem_adr, 32'h8);
    tick(1'b1, 1'b1);
    check("ackabort_valid", {31'd0, instr_valid}, 32'd1);
    check("ackabort_instr", instr, mem_word(32'h8));
    check("ackabort_pc4", instr_pc4, 32'hC);
    check("ackabort_adr", imem_adr, 32'hC);

    // Redirect while 0xC is outstanding, ack arrives three cycles later
    do_reset();
    instr_ready = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("redir_pre_adr", imem_adr, 32'hC);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(1'b0, 1'b0);
    redirect = 1'b0;
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_occ", {29'd0, occupancy}, 32'd0);
    check("redir_hold_adr", imem_adr, 32'hC);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("redir_hold_req", {31'd0, imem_req}, 32'd1);
    tick(1'b1, 1'b0);
    check("redir_drop_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_new_adr", imem_adr, 32'h100);
    tick(1'b1, 1'b0);
    check("redir_first_pc4", instr_pc4, 32'h104);
    check("redir_first_valid", {31'd0, instr_valid}, 32'd1);

    // Redirect coinciding with pop and push while FIFO holds 2
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("rpp_pre_occ", {29'd0, occupancy}, 32'd2);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick(1'b1, 1'b0);
    redirect = 1'b0;
    check("rpp_occ", {29'd0, occupancy}, 32'd0);
    check("rpp_valid", {31'd0, instr_valid}, 32'd0);
    check("rpp_adr", imem_adr, 32'h200);
    tick(1'b1, 1'b0);
    check("rpp_head_pc4", instr_pc4, 32'h204);
    check("rpp_head_instr", instr, mem_word(32'h200));
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);

    // Memory never acks: sticky timeout
    do_reset();
    instr_ready = 1'b1;
    tick(1'b0, 1'b0);
    for (int k = 0; k < 14; k++) tick(1'b0, 1'b0);
    check("to_before", {31'd0, fetch_timeout}, 32'd0);
    tick(1'b0, 1'b0);
    check("to_set", {31'd0, fetch_timeout}, 32'd1);
    check("to_req_held", {31'd0, imem_req}, 32'd1);
    tick(1'b1, 1'b0);
    check("to_sticky", {31'd0, fetch_timeout}, 32'd1);
    check("to_ack_valid", {31'd0, instr_valid}, 32'd1);
    reset = 1'b0;
    tick(1'b1, 1'b0);
    check("to_clear", {31'd0, fetch_timeout}, 32'd0);
    check("midreq_rst_req", {31'd0, imem_req}, 32'd0);
    check("midreq_rst_occ", {29'd0, occupancy}, 32'd0);
    tick(1'b1, 1'b0);
    check("midreq_rst_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
